// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART core with TX/RX FIFOs.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word fall-through FIFO; pushes when full and pops when empty are ignored.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                level <= level + 1'b1;
            else if (do_pop && !do_push)
                level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_fifo_core.sv
// UART transmitter and receiver, each buffered by a small FIFO, with sticky line-error flags.
module uart_fifo_core
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter parity_e     PARITY       = PAR_NONE,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           tx_data,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    output logic                       txd,
    input  logic                       rxd,
    output logic [WIDTH-1:0]           rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic [$clog2(DEPTH+1)-1:0] tx_level,
    output logic [$clog2(DEPTH+1)-1:0] rx_level,
    output logic                       parity_err,
    output logic                       frame_err,
    output logic                       overrun_err,
    input  logic                       err_clr
);

    localparam int unsigned CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic          ODD      = (PARITY == PAR_ODD);

    logic [WIDTH-1:0] tx_head;
    logic             tx_full, tx_empty, tx_pop;
    logic             rx_full, rx_empty, rx_push;

    uart_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_valid), .push_data(tx_data), .pop(tx_pop),
        .head(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
    );

    assign tx_ready = !tx_full;

    tx_state_e        tx_state, tx_state_n;
    logic [CW-1:0]    tx_cnt, tx_cnt_n;
    logic [3:0]       tx_idx, tx_idx_n;
    logic [WIDTH-1:0] tx_shift, tx_shift_n;
    logic             tx_par, tx_par_n, txd_n, tx_load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_shift <= tx_shift_n;
            tx_par   <= tx_par_n;
            txd      <= txd_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 1'b1;
        tx_idx_n   = tx_idx;
        tx_shift_n = tx_shift;
        tx_par_n   = tx_par;
        tx_load    = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = '0;
                tx_load  = !tx_empty;
            end
            TX_START: if (tx_cnt == CNT_LAST) begin
                tx_cnt_n   = '0;
                tx_idx_n   = '0;
                tx_state_n = TX_DATA;
            end
            TX_DATA: if (tx_cnt == CNT_LAST) begin
                tx_cnt_n   = '0;
                tx_shift_n = tx_shift >> 1;
                if (tx_idx == 4'(WIDTH - 1)) begin
                    tx_idx_n   = '0;
                    tx_state_n = (PARITY == PAR_NONE) ? TX_STOP : TX_PARITY;
                end else begin
                    tx_idx_n = tx_idx + 1'b1;
                end
            end
            TX_PARITY: if (tx_cnt == CNT_LAST) begin
                tx_cnt_n   = '0;
                tx_idx_n   = '0;
                tx_state_n = TX_STOP;
            end
            TX_STOP: if (tx_cnt == CNT_LAST) begin
                tx_cnt_n = '0;
                if (tx_idx == 4'(STOP_BITS - 1)) begin
                    tx_state_n = TX_IDLE;
                    tx_load    = !tx_empty;
                end else begin
                    tx_idx_n = tx_idx + 1'b1;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
        // Loading in the final stop cycle chains frames with no idle gap.
        if (tx_load) begin
            tx_state_n = TX_START;
            tx_cnt_n   = '0;
            tx_shift_n = tx_head;
            tx_par_n   = (^tx_head) ^ ODD;
        end
        tx_pop = tx_load;
        case (tx_state_n)
            TX_START:  txd_n = 1'b0;
            TX_DATA:   txd_n = tx_shift_n[0];
            TX_PARITY: txd_n = tx_par_n;
            default:   txd_n = 1'b1;
        endcase
    end

    logic [1:0]       rx_sync;
    logic             rx_prev, rxd_s, rx_fall;
    rx_state_e        rx_state, rx_state_n;
    logic [CW-1:0]    rx_cnt, rx_cnt_n;
    logic [3:0]       rx_idx, rx_idx_n;
    logic [WIDTH-1:0] rx_shift, rx_shift_n;
    logic             rx_par, rx_par_n, par_ev, frm_ev, ovr_ev;

    assign rxd_s   = rx_sync[1];
    assign rx_fall = rx_prev && !rxd_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync     <= '1;
            rx_prev     <= 1'b1;
            rx_state    <= RX_IDLE;
            rx_cnt      <= '0;
            rx_idx      <= '0;
            rx_shift    <= '0;
            rx_par      <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], rxd};
            rx_prev  <= rxd_s;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_idx   <= rx_idx_n;
            rx_shift <= rx_shift_n;
            rx_par   <= rx_par_n;
            if (par_ev)       parity_err  <= 1'b1;
            else if (err_clr) parity_err  <= 1'b0;
            if (frm_ev)       frame_err   <= 1'b1;
            else if (err_clr) frame_err   <= 1'b0;
            if (ovr_ev)       overrun_err <= 1'b1;
            else if (err_clr) overrun_err <= 1'b0;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 1'b1;
        rx_idx_n   = rx_idx;
        rx_shift_n = rx_shift;
        rx_par_n   = rx_par;
        rx_push    = 1'b0;
        par_ev     = 1'b0;
        frm_ev     = 1'b0;
        ovr_ev     = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (rx_fall) rx_state_n = RX_START;
            end
            RX_START: if (rx_cnt == CNT_HALF) begin
                rx_cnt_n   = '0;
                rx_idx_n   = '0;
                rx_state_n = rxd_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt == CNT_LAST) begin
                rx_cnt_n   = '0;
                rx_shift_n = {rxd_s, rx_shift[WIDTH-1:1]};
                if (rx_idx == 4'(WIDTH - 1)) begin
                    rx_idx_n   = '0;
                    rx_state_n = (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
                end else begin
                    rx_idx_n = rx_idx + 1'b1;
                end
            end
            RX_PARITY: if (rx_cnt == CNT_LAST) begin
                rx_cnt_n   = '0;
                rx_par_n   = rxd_s;
                rx_state_n = RX_STOP;
            end
            RX_STOP: if (rx_cnt == CNT_LAST) begin
                rx_cnt_n   = '0;
                rx_state_n = RX_IDLE;
                frm_ev     = !rxd_s;
                par_ev     = (PARITY != PAR_NONE) && (((^rx_shift) ^ rx_par) != ODD);
                rx_push    = !frm_ev && !par_ev;
                ovr_ev     = rx_push && rx_full;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    uart_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .push_data(rx_shift), .pop(rx_ready),
        .head(rx_data), .full(rx_full), .empty(rx_empty), .level(rx_level)
    );

    assign rx_valid = !rx_empty;

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench: an even-parity instance exercises TX, an odd-parity instance exercises RX.
module tb_uart_fifo_core;
    import uart_pkg::*;

    logic       clk;
    logic       reset;
    int         n_cmp;
    int         n_bad;

    logic [7:0] tx_data_e, rx_data_e;
    logic       tx_valid_e, tx_ready_e, txd_e, rxd_e, rx_valid_e, rx_ready_e;
    logic [2:0] tx_level_e, rx_level_e;
    logic       parity_err_e, frame_err_e, overrun_err_e, err_clr_e;

    logic [7:0] tx_data_o, rx_data_o;
    logic       tx_valid_o, tx_ready_o, txd_o, rxd_o, rx_valid_o, rx_ready_o;
    logic [2:0] tx_level_o, rx_level_o;
    logic       parity_err_o, frame_err_o, overrun_err_o, err_clr_o;

    uart_fifo_core #(.WIDTH(8), .DEPTH(4), .CLKS_PER_BIT(16), .PARITY(PAR_EVEN), .STOP_BITS(1)) u_even (
        .clk(clk), .reset(reset), .tx_data(tx_data_e), .tx_valid(tx_valid_e), .tx_ready(tx_ready_e),
        .txd(txd_e), .rxd(rxd_e), .rx_data(rx_data_e), .rx_valid(rx_valid_e), .rx_ready(rx_ready_e),
        .tx_level(tx_level_e), .rx_level(rx_level_e), .parity_err(parity_err_e), .frame_err(frame_err_e),
        .overrun_err(overrun_err_e), .err_clr(err_clr_e)
    );

    uart_fifo_core #(.WIDTH(8), .DEPTH(4), .CLKS_PER_BIT(16), .PARITY(PAR_ODD), .STOP_BITS(1)) u_odd (
        .clk(clk), .reset(reset), .tx_data(tx_data_o), .tx_valid(tx_valid_o), .tx_ready(tx_ready_o),
        .txd(txd_o), .rxd(rxd_o), .rx_data(rx_data_o), .rx_valid(rx_valid_o), .rx_ready(rx_ready_o),
        .tx_level(tx_level_o), .rx_level(rx_level_o), .parity_err(parity_err_o), .frame_err(frame_err_o),
        .overrun_err(overrun_err_o), .err_clr(err_clr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Even-parity TX frame bit k: start, 8 data LSB first, parity, stop.
    function automatic logic tx_bit(input logic [7:0] d, input int unsigned k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (k == 9) return ^d;
        return 1'b1;
    endfunction

    function automatic logic [10:0] rx_frame(input logic [7:0] d, input logic bad_par, input logic stop);
        return {stop, (~^d) ^ bad_par, d, 1'b0};
    endfunction

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int unsigned first, input int unsigned last);
        for (int unsigned k = first; k <= last; k++) begin
            rxd_o = f[k];
            step(16);
        end
    endtask

    task automatic idle_rx(input int unsigned n);
        rxd_o = 1'b1;
        step(n);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(3);
        n_cmp++; if (txd_e !== 1'b1) begin n_bad++; $display("FAIL reset_txd_e: got %b expected 1", txd_e); end
        n_cmp++; if (txd_o !== 1'b1) begin n_bad++; $display("FAIL reset_txd_o: got %b expected 1", txd_o); end
        n_cmp++; if (tx_ready_e !== 1'b1) begin n_bad++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready_e); end
        n_cmp++; if (tx_level_e !== 3'd0) begin n_bad++; $display("FAIL reset_tx_level: got %0d expected 0", tx_level_e); end
        n_cmp++; if (rx_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid_o); end
        n_cmp++; if (rx_level_o !== 3'd0) begin n_bad++; $display("FAIL reset_rx_level: got %0d expected 0", rx_level_o); end
        n_cmp++; if (rx_data_o !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data: got %h expected 00", rx_data_o); end
        n_cmp++; if ({parity_err_o, frame_err_o, overrun_err_o} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b expected 000", {parity_err_o, frame_err_o, overrun_err_o}); end
        reset = 1'b1;
        step(3);
    endtask

    task automatic test_tx_frame();
        logic [10:0] seq;
        seq = 11'b1_0_10100101_0;
        for (int unsigned c = 0; c < 182; c++) begin
            tx_data_e  = 8'hA5;
            tx_valid_e = (c == 0);
            if (c == 1) begin
                n_cmp++; if (txd_e !== 1'b1) begin n_bad++; $display("FAIL tx1_pre_start: got %b expected 1", txd_e); end
                n_cmp++; if (tx_level_e !== 3'd1) begin n_bad++; $display("FAIL tx1_level_after_push: got %0d expected 1", tx_level_e); end
            end
            if (c == 2) begin
                n_cmp++; if (tx_level_e !== 3'd0) begin n_bad++; $display("FAIL tx1_level_after_pop: got %0d expected 0", tx_level_e); end
            end
            if (c >= 2 && c < 178) begin
                n_cmp++; if (txd_e !== seq[(c-2)/16]) begin n_bad++; $display("FAIL tx1_bit%0d cyc%0d: got %b expected %b", (c-2)/16, (c-2)%16, txd_e, seq[(c-2)/16]); end
            end
            if (c >= 178) begin
                n_cmp++; if (txd_e !== 1'b1) begin n_bad++; $display("FAIL tx1_idle_after: got %b expected 1", txd_e); end
            end
            step(1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [4];
        int unsigned t;
        b[0] = 8'h01; b[1] = 8'hFF; b[2] = 8'h3C; b[3] = 8'h80;
        for (int unsigned c = 0; c < 710; c++) begin
            if (c < 4) begin
                tx_data_e  = b[c];
                tx_valid_e = 1'b1;
                n_cmp++; if (tx_ready_e !== 1'b1) begin n_bad++; $display("FAIL b2b_tx_ready push%0d: got %b expected 1", c, tx_ready_e); end
            end else begin
                tx_valid_e = 1'b0;
            end
            if (c == 4) begin
                n_cmp++; if (tx_level_e !== 3'd3) begin n_bad++; $display("FAIL b2b_level: got %0d expected 3", tx_level_e); end
            end
            if (c >= 2 && c < 706) begin
                t = c - 2;
                n_cmp++; if (txd_e !== tx_bit(b[t/176], (t%176)/16)) begin n_bad++; $display("FAIL b2b_frame%0d_bit%0d: got %b expected %b", t/176, (t%176)/16, txd_e, tx_bit(b[t/176], (t%176)/16)); end
            end
            if (c >= 706) begin
                n_cmp++; if (txd_e !== 1'b1) begin n_bad++; $display("FAIL b2b_idle_after: got %b expected 1", txd_e); end
            end
            step(1);
        end
        n_cmp++; if (tx_level_e !== 3'd0) begin n_bad++; $display("FAIL b2b_level_end: got %0d expected 0", tx_level_e); end
    endtask

    task automatic test_rx_frame();
        logic [10:0] f;
        f = rx_frame(8'h3C, 1'b0, 1'b1);
        send_bits(f, 0, 9);
        n_cmp++; if (rx_valid_o !== 1'b0) begin n_bad++; $display("FAIL rx3_valid_before_stop: got %b expected 0", rx_valid_o); end
        send_bits(f, 10, 10);
        n_cmp++; if (rx_valid_o !== 1'b1) begin n_bad++; $display("FAIL rx3_valid: got %b expected 1", rx_valid_o); end
        n_cmp++; if (rx_data_o !== 8'h3C) begin n_bad++; $display("FAIL rx3_data: got %h expected 3c", rx_data_o); end
        n_cmp++; if (rx_level_o !== 3'd1) begin n_bad++; $display("FAIL rx3_level: got %0d expected 1", rx_level_o); end
        n_cmp++; if ({parity_err_o, frame_err_o, overrun_err_o} !== 3'b000) begin n_bad++; $display("FAIL rx3_flags: got %b expected 000", {parity_err_o, frame_err_o, overrun_err_o}); end
        rx_ready_o = 1'b1;
        step(1);
        rx_ready_o = 1'b0;
        n_cmp++; if (rx_valid_o !== 1'b0) begin n_bad++; $display("FAIL rx3_valid_after_pop: got %b expected 0", rx_valid_o); end
        idle_rx(4);
    endtask

    task automatic test_rx_errors();
        send_bits(rx_frame(8'h3C, 1'b1, 1'b1), 0, 10);
        idle_rx(4);
        n_cmp++; if (parity_err_o !== 1'b1) begin n_bad++; $display("FAIL rx4_parity_err: got %b expected 1", parity_err_o); end
        n_cmp++; if (frame_err_o !== 1'b0) begin n_bad++; $display("FAIL rx4_frame_err_early: got %b expected 0", frame_err_o); end
        n_cmp++; if (rx_level_o !== 3'd0) begin n_bad++; $display("FAIL rx4_level_par: got %0d expected 0", rx_level_o); end
        send_bits(rx_frame(8'h3C, 1'b0, 1'b0), 0, 10);
        idle_rx(4);
        n_cmp++; if (frame_err_o !== 1'b1) begin n_bad++; $display("FAIL rx4_frame_err: got %b expected 1", frame_err_o); end
        n_cmp++; if (parity_err_o !== 1'b1) begin n_bad++; $display("FAIL rx4_parity_sticky: got %b expected 1", parity_err_o); end
        n_cmp++; if (rx_level_o !== 3'd0) begin n_bad++; $display("FAIL rx4_level_frm: got %0d expected 0", rx_level_o); end
        err_clr_o = 1'b1;
        step(1);
        err_clr_o = 1'b0;
        n_cmp++; if ({parity_err_o, frame_err_o} !== 2'b00) begin n_bad++; $display("FAIL rx4_err_clr: got %b expected 00", {parity_err_o, frame_err_o}); end
    endtask

    task automatic test_rx_overrun();
        logic [7:0] b [5];
        b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44; b[4] = 8'h55;
        for (int unsigned i = 0; i < 4; i++) begin
            send_bits(rx_frame(b[i], 1'b0, 1'b1), 0, 10);
            idle_rx(4);
        end
        n_cmp++; if (rx_level_o !== 3'd4) begin n_bad++; $display("FAIL rx5_level_full: got %0d expected 4", rx_level_o); end
        n_cmp++; if (overrun_err_o !== 1'b0) begin n_bad++; $display("FAIL rx5_overrun_early: got %b expected 0", overrun_err_o); end
        send_bits(rx_frame(b[4], 1'b0, 1'b1), 0, 10);
        idle_rx(4);
        n_cmp++; if (rx_level_o !== 3'd4) begin n_bad++; $display("FAIL rx5_level_after: got %0d expected 4", rx_level_o); end
        n_cmp++; if (overrun_err_o !== 1'b1) begin n_bad++; $display("FAIL rx5_overrun: got %b expected 1", overrun_err_o); end
        for (int unsigned i = 0; i < 4; i++) begin
            n_cmp++; if (rx_data_o !== b[i]) begin n_bad++; $display("FAIL rx5_read%0d: got %h expected %h", i, rx_data_o, b[i]); end
            rx_ready_o = 1'b1;
            step(1);
            rx_ready_o = 1'b0;
        end
        n_cmp++; if (rx_valid_o !== 1'b0) begin n_bad++; $display("FAIL rx5_drained: got %b expected 0", rx_valid_o); end
        err_clr_o = 1'b1;
        step(1);
        err_clr_o = 1'b0;
        n_cmp++; if (overrun_err_o !== 1'b0) begin n_bad++; $display("FAIL rx5_overrun_clr: got %b expected 0", overrun_err_o); end
    endtask

    task automatic test_glitch_and_reset();
        rxd_o = 1'b0;
        step(5);
        idle_rx(40);
        n_cmp++; if (rx_level_o !== 3'd0) begin n_bad++; $display("FAIL g6_rx_level: got %0d expected 0", rx_level_o); end
        n_cmp++; if ({parity_err_o, frame_err_o} !== 2'b00) begin n_bad++; $display("FAIL g6_flags: got %b expected 00", {parity_err_o, frame_err_o}); end
        tx_data_e  = 8'h5A;
        tx_valid_e = 1'b1;
        step(1);
        tx_data_e  = 8'hC3;
        step(1);
        tx_valid_e = 1'b0;
        step(50);
        n_cmp++; if (tx_level_e !== 3'd1) begin n_bad++; $display("FAIL r6_level_pre: got %0d expected 1", tx_level_e); end
        n_cmp++; if (txd_e !== 1'b0) begin n_bad++; $display("FAIL r6_txd_pre: got %b expected 0", txd_e); end
        #3 reset = 1'b0;
        #1;
        n_cmp++; if (txd_e !== 1'b1) begin n_bad++; $display("FAIL r6_txd_in_reset: got %b expected 1", txd_e); end
        n_cmp++; if (tx_level_e !== 3'd0) begin n_bad++; $display("FAIL r6_level_in_reset: got %0d expected 0", tx_level_e); end
        n_cmp++; if (tx_ready_e !== 1'b1) begin n_bad++; $display("FAIL r6_ready_in_reset: got %b expected 1", tx_ready_e); end
        step(3);
        reset = 1'b1;
        for (int unsigned c = 0; c < 200; c++) begin
            n_cmp++; if (txd_e !== 1'b1) begin n_bad++; $display("FAIL r6_txd_after cyc%0d: got %b expected 1", c, txd_e); end
            step(1);
        end
        n_cmp++; if (tx_level_e !== 3'd0) begin n_bad++; $display("FAIL r6_level_after: got %0d expected 0", tx_level_e); end
        n_cmp++; if (rx_valid_o !== 1'b0) begin n_bad++; $display("FAIL r6_rx_valid: got %b expected 0", rx_valid_o); end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        reset      = 1'b0;
        tx_data_e  = 8'h00; tx_valid_e = 1'b0; rxd_e = 1'b1; rx_ready_e = 1'b0; err_clr_e = 1'b0;
        tx_data_o  = 8'h00; tx_valid_o = 1'b0; rxd_o = 1'b1; rx_ready_o = 1'b0; err_clr_o = 1'b0;
        #1;
        test_reset();
        test_tx_frame();
        test_back_to_back();
        test_rx_frame();
        test_rx_errors();
        test_rx_overrun();
        test_glitch_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_fifo_core.md
UART_FIFO_CORE -- requirements
Module: uart_fifo_core

Interface
REQ-001 Parameter WIDTH, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter DEPTH, default 4, entries per TX and RX FIFO; power of two, at least 2.
REQ-003 Parameter CLKS_PER_BIT, default 868, clk cycles per bit (100 MHz / 115200); at least 8.
REQ-004 Parameter PARITY, default PAR_NONE, of type uart_pkg::parity_e (PAR_NONE, PAR_EVEN, PAR_ODD).
REQ-005 Parameter STOP_BITS, default 1, number of stop bits; legal values 1 or 2.
REQ-006 Port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-007 Port reset, input, 1 bit, asynchronous active-low reset.
REQ-008 Port tx_data, input, WIDTH bits, byte to transmit.
REQ-009 Port tx_valid, input, 1 bit, tx_data offered.
REQ-010 Port tx_ready, output, 1 bit, TX FIFO can accept a byte; equals not-full.
REQ-011 Port txd, output, 1 bit, serial line out; idles high.
REQ-012 Port rxd, input, 1 bit, asynchronous serial line in.
REQ-013 Port rx_data, output, WIDTH bits, head of RX FIFO (first-word fall-through).
REQ-014 Port rx_valid, output, 1 bit, RX FIFO not empty.
REQ-015 Port rx_ready, input, 1 bit, consumer pops the head when rx_valid is also high.
REQ-016 Ports tx_level and rx_level, outputs, $clog2(DEPTH+1) bits each, FIFO occupancy.
REQ-017 Ports parity_err, frame_err and overrun_err, outputs, 1 bit each, sticky error flags.
REQ-018 Port err_clr, input, 1 bit, synchronous clear of all three error flags.

Function
REQ-019 A byte SHALL be pushed into the TX FIFO only on a cycle where tx_valid and tx_ready are both high; the byte SHALL be visible to the serialiser on the next cycle.
REQ-020 The TX FSM SHALL have the states IDLE, START, DATA, PARITY, STOP, and SHALL pop the TX FIFO on the first IDLE cycle in which the FIFO is non-empty.
REQ-021 txd SHALL go low on the cycle after the pop, so the first push at cycle N drives the start bit at cycle N+2.
REQ-022 Each bit SHALL be held on txd for exactly CLKS_PER_BIT cycles.
REQ-023 Frame order SHALL be: start bit (0), WIDTH data bits LSB first, parity bit (skipped when PAR_NONE), then STOP_BITS stop bits (1).
REQ-024 The parity bit SHALL be the XOR of the data bits for PAR_EVEN and its inverse for PAR_ODD.
REQ-025 Back-to-back frames SHALL have no idle gap: the pop for the next byte SHALL occur in the last cycle of the final stop bit.
REQ-026 rxd SHALL pass through a two-flop synchroniser before any use.
REQ-027 The RX FSM SHALL have the states IDLE, START, DATA, PARITY, STOP.
REQ-028 In IDLE, a falling edge on the synchronised rxd SHALL move the FSM to START.
REQ-029 START SHALL re-sample rxd at CLKS_PER_BIT/2; if rxd is high, the start is false and the FSM SHALL return to IDLE with no flag set.
REQ-030 After a valid start, every later bit SHALL be sampled at CLKS_PER_BIT intervals from the mid-start point.
REQ-031 Only the first stop bit SHALL be checked on receive; a low stop sample SHALL set frame_err and discard the byte.
REQ-032 A parity mismatch SHALL set parity_err and discard the byte; when both errors occur in one frame, both flags SHALL be set.
REQ-033 A good byte SHALL be written into the RX FIFO on the cycle the stop bit is sampled.
REQ-034 If the RX FIFO is full at that write, the byte SHALL be dropped, overrun_err set, and FIFO contents left unchanged.
REQ-035 On the cycle after the stop-bit sample, the RX FSM SHALL return to IDLE and SHALL accept a new falling edge.
REQ-036 A simultaneous push and pop on either FIFO SHALL leave its level unchanged.
REQ-037 FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-038 A pop on an empty FIFO and a push on a full FIFO SHALL be ignored.
REQ-039 If err_clr and an error event occur in the same cycle, the error event SHALL take priority and the flag SHALL end set.

Reset
REQ-040 While reset is low, txd SHALL be 1, both FSMs SHALL be in IDLE, both FIFOs SHALL be empty (levels 0, rx_valid 0, tx_ready 1), rx_data SHALL be 0, and all error flags SHALL be 0.
REQ-041 Reset asserted mid-frame SHALL abort that frame immediately; no partial byte SHALL be written to either FIFO after release.

Structure
REQ-042 Package uart_pkg SHALL hold parity_e, the tx_state_e and rx_state_e enums, and the default CLKS_PER_BIT constant.
REQ-043 The FIFO SHALL be one sub-module, uart_sync_fifo, parametrised by WIDTH and DEPTH and instantiated twice.

Verification
REQ-044 Scenario 1: WIDTH=8, PAR_EVEN, CLKS_PER_BIT=16, push 0xA5 -> txd reads 0,1,0,1,0,0,1,0,1,0,1, each bit 16 cycles, start bit at push+2.
REQ-045 Scenario 2: push 4 bytes in 4 consecutive cycles with DEPTH=4 -> tx_ready stays high (the first pop frees a slot), and all frames are contiguous with no gap.
REQ-046 Scenario 3: drive rxd with 0x3C framed correctly, PAR_ODD -> rx_valid rises after the stop-bit sample, rx_data=0x3C, no error flags.
REQ-047 Scenario 4: send 0x3C with a wrong parity bit, then a second frame with a low stop bit -> parity_err=1, then frame_err=1, rx_level stays 0, and err_clr clears both.
REQ-048 Scenario 5: with rx_ready=0, receive 5 frames into DEPTH=4 -> rx_level=4, overrun_err=1, and the first four bytes read out in order.
REQ-049 Scenario 6: a 0.3-bit low glitch on rxd, then reset asserted mid-transmit -> no byte received, and txd=1 immediately with tx_level=0.
